// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to three completed results per cycle onto the registered CDB lanes.
// Optional performance counters are compiled in when CDB_ARB_PERF_EN is defined.
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_LANES = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [32*NUM_REQ-1:0]    req_data,
    input  logic [8*NUM_REQ-1:0]     req_tag,
    output logic [NUM_REQ-1:0]       req_grant,
    output logic [32*NUM_LANES-1:0]  CDB_data_serialized,
    output logic [8*NUM_LANES-1:0]   CDB_tag_serialized,
    output logic                     proto_err
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]              perf_busy_cycles,
    output logic [31:0]              perf_full_cycles,
    output logic [31:0]              perf_stall_cycles
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]         rr_ptr;
    logic [PTR_W-1:0]         rr_ptr_nxt;
    logic [PTR_W-1:0]         lane_idx [NUM_LANES];
    logic [NUM_LANES-1:0]     lane_vld;
    logic [NUM_REQ-1:0]       grant;
    logic [1:0]               n_used;
    logic [PTR_W:0]           scan;
    logic [PTR_W-1:0]         idx;
    logic [PTR_W-1:0]         last_idx;
    logic [32*NUM_LANES-1:0]  cdb_data_nxt;
    logic [8*NUM_LANES-1:0]   cdb_tag_nxt;
    logic                     tag_err;

    // Scan from rr_ptr with an explicit wrap so non-power-of-two NUM_REQ works.
    always_comb begin
        grant    = '0;
        lane_vld = '0;
        n_used   = '0;
        last_idx = rr_ptr;
        scan     = '0;
        idx      = '0;
        for (int l = 0; l < NUM_LANES; l++) lane_idx[l] = '0;
        if (en && !reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (scan >= (PTR_W+1)'(NUM_REQ))
                    scan = scan - (PTR_W+1)'(NUM_REQ);
                idx = scan[PTR_W-1:0];
                if (req_valid[idx] && (n_used < 2'(NUM_LANES))) begin
                    grant[idx]       = 1'b1;
                    lane_idx[n_used] = idx;
                    lane_vld[n_used] = 1'b1;
                    last_idx         = idx;
                    n_used           = n_used + 2'd1;
                end
            end
        end
    end

    assign req_grant  = grant;
    assign rr_ptr_nxt = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);

    // Lane 0 sits in the most significant slice of each serialized bus.
    always_comb begin
        cdb_data_nxt = '0;
        cdb_tag_nxt  = '0;
        tag_err      = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (lane_vld[l] && (lane_idx[l] == PTR_W'(r))) begin
                    cdb_data_nxt[32*(NUM_LANES-1-l) +: 32] = req_data[32*r +: 32];
                    cdb_tag_nxt[8*(NUM_LANES-1-l) +: 8]    = req_tag[8*r +: 8];
                end
            end
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (req_valid[r] && !req_tag[8*r+7]) tag_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr              <= '0;
            CDB_data_serialized <= '0;
            CDB_tag_serialized  <= '0;
            proto_err           <= 1'b0;
        end else begin
            proto_err <= proto_err | tag_err;
            if (en) begin
                CDB_data_serialized <= cdb_data_nxt;
                CDB_tag_serialized  <= cdb_tag_nxt;
                if (|grant) rr_ptr <= rr_ptr_nxt;
            end else begin
                CDB_data_serialized <= '0;
                CDB_tag_serialized  <= '0;
            end
        end
    end

`ifdef CDB_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_busy_cycles  <= '0;
            perf_full_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else if (en) begin
            if ((|grant) && !(&perf_busy_cycles))
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if ((n_used == 2'(NUM_LANES)) && !(&perf_full_cycles))
                perf_full_cycles <= perf_full_cycles + 32'd1;
            if ((|(req_valid & ~grant)) && !(&perf_stall_cycles))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the 3-lane Common Data Bus (CDB) among the functional-unit reservation stations: adder, multiplier, divider and load.
- Each cycle, grants up to 3 pending results using round-robin priority.
- Registers the winners onto the serialized CDB buses that every reservation station and the register file snoop.
- Issues a per-requester grant that the reservation station uses as its offload/retire strobe.

Parameters:
- NUM_REQ, 4, number of requesting reservation stations (2..8).
- NUM_LANES, 3, CDB lanes. Fixed at 3 to match the 96/24-bit serialized bus; other values are unsupported.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  global enable. When low: no grants, and the CDB is driven idle.
- req_valid  input  NUM_REQ  bit r = requester r holds a completed result.
- req_data  input  32*NUM_REQ  result word; requester r occupies bits [32r+31:32r].
- req_tag  input  8*NUM_REQ  producer tag {valid, mem, add, div, 1'b0, id[2:0]}; requester r occupies bits [8r+7:8r].
- req_grant  output  NUM_REQ  combinational; bit r high = requester r wins a lane this cycle and retires at the clock edge.
- CDB_data_serialized  output  96  registered; lane0 = [95:64], lane1 = [63:32], lane2 = [31:0].
- CDB_tag_serialized  output  8*NUM_LANES (24)  registered; lane0 = [23:16], lane1 = [15:8], lane2 = [7:0]. An idle lane carries tag 8'h00 and data 0.
- proto_err  output  1  sticky; set when a request has valid=1 but req_tag[7]=0.

Behaviour:
- Reset (synchronous, active-high, takes precedence over en):
  - rr_ptr = 0, CDB_data_serialized = 0, CDB_tag_serialized = 0, proto_err = 0.
  - req_grant = 0 while reset is high.
  - Reset mid-operation drops any in-flight lane contents at that edge. Requesters keep their valid asserted and are re-arbitrated after reset.
- Arbitration (combinational, only when en=1 and reset=0):
  - Scan requesters in the order rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - The first valid requester found gets lane0, the second lane1, the third lane2.
  - Remaining valid requesters get no grant and must hold.
- Handshake:
  - A requester holds req_valid, req_data and req_tag stable until it sees req_grant high in the same cycle.
  - It frees its entry at that clock edge and may present a new result the next cycle.
  - req_grant must not feed back combinationally into req_valid.
- Latency: a result granted in cycle N appears on its CDB lane in cycle N+1, for exactly one cycle. Lanes not granted in cycle N are idle (all zero) in N+1.
- Pointer update at each enabled edge:
  - If at least one grant was issued: rr_ptr <= (index of the last granted requester + 1) mod NUM_REQ.
  - If no grant was issued: rr_ptr holds.
- Fairness: with NUM_REQ=4 and all requesters continuously valid, every requester is granted at least once in any 2 consecutive cycles.
- en=0:
  - No grants and rr_ptr holds.
  - The CDB registers load all-zero, so lanes are idle the following cycle. This prevents stale results from being re-captured by snoopers.
- Simultaneous events:
  - A requester deasserting valid in the same cycle it would have won does not consume a lane.
  - Lanes fill strictly in scan order with no gaps: with 1 winner only lane0 is used; with 2 winners lanes 0 and 1.
- Tag integrity:
  - Data is forwarded unchanged; the tag is forwarded as presented.
  - A valid request whose tag has bit7=0 is still granted, and proto_err latches to 1 until reset.
- Arithmetic: rr_ptr is $clog2(NUM_REQ) bits, and the wrap is explicit (not a power-of-two overflow) so that non-power-of-two NUM_REQ works.

Optional Feature:
- Macro: CDB_ARB_PERF_EN.
- When defined, three extra outputs are added, all cleared on reset, incremented only when en=1, and saturating at all-ones:
  - perf_busy_cycles (32 bits): counts cycles with at least one grant.
  - perf_full_cycles (32 bits): counts cycles in which all 3 lanes were granted.
  - perf_stall_cycles (32 bits): counts cycles in which at least one valid requester went ungranted.
- When undefined, these ports and counters do not exist and all behaviour is otherwise identical.

Test Plan:
- Single request: reset, then req_valid=4'b0100, req_tag[23:16]=8'h92, req_data[95:64]=32'd7 for one cycle → req_grant=4'b0100 that cycle; next cycle CDB_tag_serialized=24'h920000, CDB_data_serialized[95:64]=7; rr_ptr=3.
- Oversubscription: all 4 valid from rr_ptr=0 → cycle 1 grants r0,r1,r2 on lanes 0,1,2 and rr_ptr=3; r3 holds; cycle 2 grants r3 on lane0 and rr_ptr=0.
- Round-robin wrap: rr_ptr=3, valid=4'b1011 → r3 gets lane0, r0 lane1, r1 lane2; new rr_ptr=2.
- en low: valid=4'b1111 with en=0 for 2 cycles → req_grant=0, CDB tag bus=24'h000000 from the cycle after en falls, rr_ptr unchanged; on en=1, arbitration resumes from the held rr_ptr.
- Mid-operation reset: grant r1 in cycle N, assert reset at edge N → CDB outputs 0 in N+1, rr_ptr=0, no grant while reset high; after release, r1 (still valid) is granted lane0.
- Protocol error: valid request with tag 8'h12 → granted and broadcast unchanged, proto_err=1 from the next cycle and stays 1 until reset.
